fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 104 ++++++++++
 tb/tb_fp_mul_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency FP multiplier.
// Tags each issue with its owner and routes the returning product back in issue order.
module fp_mul_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned W       = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         mul_valid,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic         mul_ready,
    input  logic [W-1:0] mul_result,
    input  logic [W-1:0] mul_op_delay,
    output logic         res0_valid,
    output logic         res1_valid,
    output logic [W-1:0] res_data,
    output logic [W-1:0] res_op,
    output logic         busy,
    output logic         err
);

    localparam int unsigned CW = $clog2(LATENCY + 2);

    logic               gnt0;
    logic               gnt1;
    logic               grant;
    logic               last_gnt;
    logic               issue_own;
    logic [LATENCY-1:0] tag_vld;
    logic [LATENCY-1:0] tag_own;
    logic               head_vld;
    logic               head_own;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;

    // Arbitration: on conflict the requester not granted last time wins.
    always_comb begin
        gnt0       = req0_valid & (~req1_valid | last_gnt);
        gnt1       = req1_valid & (~req0_valid | ~last_gnt);
        grant      = gnt0 | gnt1;
        req0_ready = gnt0;
        req1_ready = gnt1;
    end

    // Result routing straight off the tag head; stale strobes with no tag are dropped.
    always_comb begin
        head_vld   = tag_vld[LATENCY-1];
        head_own   = tag_own[LATENCY-1];
        res0_valid = mul_ready & head_vld & ~head_own;
        res1_valid = mul_ready & head_vld & head_own;
        res_data   = mul_result;
        res_op     = mul_op_delay;
    end

    always_comb begin
        count_nxt = count;
        unique case ({grant, head_vld})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            issue_own <= 1'b0;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            tag_vld   <= '0;
            tag_own   <= '0;
            count     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mul_valid <= grant;
            if (grant) begin
                last_gnt  <= gnt1;
                issue_own <= gnt1;
                mul_a     <= gnt1 ? req1_a : req0_a;
                mul_b     <= gnt1 ? req1_b : req0_b;
            end
            // Head retires every cycle whether or not the multiplier answered.
            tag_vld <= (tag_vld << 1) | LATENCY'(mul_valid);
            tag_own <= (tag_own << 1) | LATENCY'(issue_own);
            count   <= count_nxt;
            busy    <= (count_nxt != '0);
            if (head_vld && !mul_ready) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter with a behavioural fixed-latency multiplier.
module tb_fp_mul_arbiter;

    localparam int unsigned LAT = 2;
    localparam int unsigned W   = 31;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         mul_valid, mul_ready;
    logic [W-1:0] mul_a, mul_b, mul_result, mul_op_delay;
    logic         res0_valid, res1_valid;
    logic [W-1:0] res_data, res_op;
    logic         busy, err;

    fp_mul_arbiter #(.LATENCY(LAT), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_result(mul_result), .mul_op_delay(mul_op_delay),
        .res0_valid(res0_valid), .res1_valid(res1_valid),
        .res_data(res_data), .res_op(res_op), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    logic [31:0] drop_cyc = 32'hFFFF_FFFF;
    logic        force_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Operand table (1.0*2.0, 1.5*1.5, 3.0*0.5, 2.0*2.0, 1.5*2.0) and hand-computed products.
    logic [W-1:0] pa [5] = '{31'h3F800000, 31'h3FC00000, 31'h40400000, 31'h40000000, 31'h3FC00000};
    logic [W-1:0] pb [5] = '{31'h40000000, 31'h3FC00000, 31'h3F000000, 31'h40000000, 31'h40000000};
    logic [W-1:0] pp [5] = '{31'h40000000, 31'h40100000, 31'h3FC00000, 31'h40800000, 31'h40400000};

    // Behavioural multiplier: unsigned normal floats, truncating.
    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [23:0] ma, mb;
        logic [47:0] p;
        logic [8:0]  e;
        logic [22:0] m;
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        p  = 48'(ma) * 48'(mb);
        e  = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 9'd1;
        end else begin
            m = p[45:23];
        end
        return {e[7:0], m};
    endfunction

    logic [LAT-1:0] m_vld = '0;
    logic [W-1:0]   m_a [LAT];
    logic [W-1:0]   m_b [LAT];

    initial for (int i = 0; i < int'(LAT); i++) begin m_a[i] = '0; m_b[i] = '0; end

    always @(posedge clk) begin
        m_vld <= {m_vld[LAT-2:0], mul_valid};
        m_a[0] <= mul_a;
        m_b[0] <= mul_b;
        for (int i = 1; i < int'(LAT); i++) begin
            m_a[i] <= m_a[i-1];
            m_b[i] <= m_b[i-1];
        end
    end

    assign mul_ready    = (m_vld[LAT-1] && cyc != drop_cyc) || force_ready;
    assign mul_result   = fmul(m_a[LAT-1], m_b[LAT-1]);
    assign mul_op_delay = m_a[LAT-1];

    typedef struct packed {
        logic         own;
        logic [W-1:0] data;
        logic [W-1:0] op;
        logic [31:0]  due;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (res0_valid || res1_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%b%b required=00 (cycle %0d)",
                         res1_valid, res0_valid, cyc);
            end else begin
                e = q.pop_front();
                check("res_owner", {30'd0, res1_valid, res0_valid}, e.own ? 32'd2 : 32'd1);
                check("res_data", {1'b0, res_data}, {1'b0, e.data});
                check("res_op", {1'b0, res_op}, {1'b0, e.op});
                check("res_cycle", cyc, e.due);
            end
        end
    end

    // One stimulus cycle: present requests, check grants, record expected results.
    task automatic step(input logic v0, input int p0, input logic v1, input int p1,
                        input logic e0, input logic e1, input bit push = 1'b1);
        req0_valid = v0; req0_a = pa[p0]; req0_b = pb[p0];
        req1_valid = v1; req1_a = pa[p1]; req1_b = pb[p1];
        #1;
        check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        if (push && req0_ready) q.push_back('{own: 1'b0, data: pp[p0], op: pa[p0], due: cyc + 32'(LAT + 1)});
        if (push && req1_ready) q.push_back('{own: 1'b1, data: pp[p1], op: pa[p1], due: cyc + 32'(LAT + 1)});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mul_valid", {31'd0, mul_valid}, 32'd0);
        check("rst_mul_a", {1'b0, mul_a}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] c;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_mul_b", {1'b0, mul_b}, 32'd0);
        rst_n = 1'b1;

        // Single request, granted on the first edge after reset release.
        step(1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
        check("issue_valid", {31'd0, mul_valid}, 32'd1);
        check("issue_a", {1'b0, mul_a}, {1'b0, pa[0]});
        check("issue_b", {1'b0, mul_b}, {1'b0, pb[0]});
        check("issue_busy", {31'd0, busy}, 32'd1);
        idle(1);
        check("idle_valid", {31'd0, mul_valid}, 32'd0);
        check("idle_hold_a", {1'b0, mul_a}, {1'b0, pa[0]});
        idle(3);

        // Conflict after reset: strict alternation starting with requester 0.
        pulse_reset();
        for (int k = 0; k < 6; k++)
            step(1'b1, k % 5, 1'b1, (k + 2) % 5, (k % 2) == 0, (k % 2) == 1);
        check("conf_busy_a", {31'd0, busy}, 32'd1);
        idle(2);
        check("conf_busy_b", {31'd0, busy}, 32'd1);
        idle(1);
        check("conf_busy_done", {31'd0, busy}, 32'd0);

        // Back-to-back requester 1.
        for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, k, 1'b0, 1'b1);
        idle(4);
        check("b2b_err", {31'd0, err}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd0);

        // Reset one cycle before the first result: in-flight ops are discarded.
        step(1'b1, 1, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 2, 1'b0, 1'b1);
        pulse_reset();
        idle(3);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        step(1'b1, 3, 1'b1, 4, 1'b1, 1'b0);
        idle(4);

        // Suppressed multiplier strobe: sticky err, neighbours still routed.
        c = cyc;
        drop_cyc = c + 32'd1 + 32'(LAT + 1);
        step(1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 2, 1'b0, 1'b1);
        idle(1);
        check("fault_err_before", {31'd0, err}, 32'd0);
        idle(1);
        check("fault_err_set", {31'd0, err}, 32'd1);
        idle(3);
        step(1'b1, 4, 1'b0, 0, 1'b1, 1'b0);
        idle(4);
        check("fault_err_sticky", {31'd0, err}, 32'd1);
        drop_cyc = 32'hFFFF_FFFF;

        // Stale strobe with nothing in flight.
        pulse_reset();
        check("stale_err_cleared", {31'd0, err}, 32'd0);
        force_ready = 1'b1;
        idle(1);
        force_ready = 1'b0;
        idle(2);
        check("stale_err", {31'd0, err}, 32'd0);
        check("stale_busy", {31'd0, busy}, 32'd0);

        check("drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
